// File: rtl/seq_alu_pkg.sv
// Shared op-code constants and FSM state type for the sequential ALU.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOR  = 4'h5;
   localparam logic [3:0] OP_SLL  = 4'h6;
   localparam logic [3:0] OP_SRL  = 4'h7;
   localparam logic [3:0] OP_SRA  = 4'h8;
   localparam logic [3:0] OP_SLT  = 4'h9;
   localparam logic [3:0] OP_CLZ  = 4'hA;
   localparam logic [3:0] OP_CLO  = 4'hB;
   localparam logic [3:0] OP_MULT = 4'hC;
   localparam logic [3:0] OP_DIV  = 4'hD;
   localparam logic [3:0] OP_LUI  = 4'hE;
   localparam logic [3:0] OP_SEQ  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per step, on operand magnitudes.
// Outputs are the sign-corrected results of the current step, valid in the cycle last_o is high.
module seq_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic             sign_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             ovf_o
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d, den_q;
   logic [CW-1:0]      cnt_q;
   logic               div_q, neg_q, rneg_q, ovf_q;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     sum, trial;
   logic [2*WIDTH-1:0] prod_neg;

   assign mag_a = (sign_i && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
   assign mag_b = (sign_i && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;

   // acc holds the running product high half / partial remainder; sh the multiplier / quotient.
   always_comb begin
      acc_d = acc_q;
      sh_d  = sh_q;
      sum   = '0;
      trial = {acc_q, sh_q[WIDTH-1]} - {1'b0, den_q};
      if (div_q) begin
         if (!trial[WIDTH]) begin
            acc_d = trial[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, den_q} : '0);
         acc_d = sum[WIDTH:1];
         sh_d  = {sum[0], sh_q[WIDTH-1:1]};
      end
   end

   assign prod_neg = '0 - {acc_d, sh_d};
   assign hi_o   = div_q ? (rneg_q ? ('0 - acc_d) : acc_d) : (neg_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_d);
   assign lo_o   = div_q ? (neg_q ? ('0 - sh_d) : sh_d) : (neg_q ? prod_neg[WIDTH-1:0] : sh_d);
   assign ovf_o  = ovf_q;
   assign last_o = (cnt_q == CW'(WIDTH-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         sh_q   <= '0;
         den_q  <= '0;
         cnt_q  <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (load_i) begin
         acc_q  <= '0;
         sh_q   <= mag_a;
         den_q  <= mag_b;
         cnt_q  <= '0;
         div_q  <= is_div_i;
         neg_q  <= sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
         rneg_q <= sign_i & a_i[WIDTH-1];
         ovf_q  <= is_div_i && sign_i && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
      end else if (step_i) begin
         acc_q  <= acc_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete one cycle after start, MULT/DIV take WIDTH iterations.
// No backpressure: start is accepted only when not busy and is otherwise dropped.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit CLZ_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             zero,
   output logic             overflow,
   output logic             div_zero
);
   localparam int SW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, hi_q, lo_q, alu_res, md_hi, md_lo;
   logic             zero_q, ovf_q, dz_q, alu_ovf, alu_dz, md_last, md_ovf;
   logic             load, step, cap_single, cap_md;
   logic [WIDTH:0]   sum_w, diff_w;
   logic [SW-1:0]    shamt;

   function automatic logic [WIDTH-1:0] lead_zeros(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] n;
      n = WIDTH'(WIDTH);
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) n = WIDTH'(WIDTH - 1 - i);
      return n;
   endfunction

   assign shamt  = b[SW-1:0];
   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_dz  = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_ovf = sign ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1])) : sum_w[WIDTH];
         end
         OP_SUB: begin
            alu_res = diff_w[WIDTH-1:0];
            alu_ovf = sign ? ((a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1])) : diff_w[WIDTH];
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         OP_SLT:  alu_res = WIDTH'(sign ? ($signed(a) < $signed(b)) : (a < b));
         OP_CLZ:  alu_res = CLZ_EN ? lead_zeros(a) : '0;
         OP_CLO:  alu_res = CLZ_EN ? lead_zeros(~a) : '0;
         // Only reaches the single-cycle path when the divisor is zero.
         OP_DIV: begin
            alu_res = '1;
            alu_dz  = 1'b1;
         end
         OP_LUI:  alu_res = b << 16;
         OP_SEQ:  alu_res = WIDTH'(a == b);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      step       = 1'b0;
      cap_single = 1'b0;
      cap_md     = 1'b0;
      case (state_q)
         ST_ITER: begin
            step = 1'b1;
            if (md_last) begin
               state_d = ST_DONE;
               cap_md  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (start) begin
               if (op == OP_MULT || (op == OP_DIV && b != '0)) begin
                  state_d = ST_ITER;
                  load    = 1'b1;
               end else begin
                  state_d    = ST_DONE;
                  cap_single = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cap_single) begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
            ovf_q    <= alu_ovf;
            dz_q     <= alu_dz;
            if (alu_dz) begin
               hi_q <= a;
               lo_q <= '1;
            end
         end else if (cap_md) begin
            result_q <= md_lo;
            hi_q     <= md_hi;
            lo_q     <= md_lo;
            zero_q   <= (md_lo == '0);
            ovf_q    <= md_ovf;
            dz_q     <= 1'b0;
         end
      end
   end

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst      (reset),
      .load_i   (load),
      .step_i   (step),
      .is_div_i (op == OP_DIV),
      .sign_i   (sign),
      .a_i      (a),
      .b_i      (b),
      .last_o   (md_last),
      .hi_o     (md_hi),
      .lo_o     (md_lo),
      .ovf_o    (md_ovf)
   );

   assign busy     = (state_q == ST_ITER);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;
   logic        clk = 1'b0;
   logic        reset, start, sign;
   logic [3:0]  op;
   logic [31:0] a, b, result, hi, lo;
   logic        busy, done, zero, overflow, div_zero;
   int          checks = 0;
   int          errors = 0;
   int          cyc, bcnt, dn;

   seq_alu #(.WIDTH(32), .CLZ_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
      .zero(zero), .overflow(overflow), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents a request for one cycle; returns #1 after the sampling edge.
   task automatic issue(input logic [3:0] o, input logic s, input logic [31:0] av, input logic [31:0] bv);
      op = o; sign = s; a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int c, output int bc);
      c = 0; bc = 0;
      while (done !== 1'b1 && c < 100) begin
         if (busy === 1'b1) bc++;
         @(posedge clk); #1;
         c++;
      end
   endtask

   task automatic single(input string tag, input logic [3:0] o, input logic s,
                         input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp);
      issue(o, s, av, bv);
      chk({tag, "_done"}, done, 1);
      chk(tag, result, exp);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 4'h0; sign = 1'b0; a = '0; b = '0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_hilo", {hi, lo}, 0);
      chk("rst_flags", {zero, overflow, div_zero}, 3'b100);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      issue(4'h0, 1'b1, 32'h7FFF_FFFF, 32'h1);
      chk("add_done", done, 1);
      chk("add_busy", busy, 0);
      chk("add_res", result, 32'h8000_0000);
      chk("add_ovf_zero", {overflow, zero}, 2'b10);
      @(posedge clk); #1;
      chk("done_pulse", done, 0);

      issue(4'h0, 1'b0, 32'hFFFF_FFFF, 32'h1);
      chk("addu_res_zero_carry", {result, zero, overflow}, {32'h0, 2'b11});
      issue(4'h1, 1'b0, 32'h0, 32'h1);
      chk("subu_borrow", {result, overflow}, {32'hFFFF_FFFF, 1'b1});
      issue(4'h1, 1'b1, 32'h8000_0000, 32'h1);
      chk("subs_ovf", {result, overflow}, {32'h7FFF_FFFF, 1'b1});
      issue(4'h1, 1'b1, 32'h5, 32'h7);
      chk("subs_noovf", {result, overflow}, {32'hFFFF_FFFE, 1'b0});
      chk("hilo_untouched", {hi, lo}, 0);

      single("and", 4'h2, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
      single("or",  4'h3, 1'b0, 32'hF0F0_0000, 32'h0F00_000F, 32'hFFF0_000F);
      single("nor", 4'h5, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);
      single("sll_mask", 4'h6, 1'b0, 32'h1, 32'h21, 32'h2);
      single("sll_zero", 4'h6, 1'b0, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
      single("srl", 4'h7, 1'b0, 32'h8000_0000, 32'h4, 32'h0800_0000);
      single("sra", 4'h8, 1'b0, 32'h8000_0000, 32'h4, 32'hF800_0000);
      single("slt_s", 4'h9, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h1);
      single("slt_u", 4'h9, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
      single("clz", 4'hA, 1'b0, 32'h0001_0000, 32'h0, 32'd15);
      single("clz0", 4'hA, 1'b0, 32'h0, 32'h0, 32'd32);
      single("clo", 4'hB, 1'b0, 32'hF000_0000, 32'h0, 32'd4);
      single("clo1", 4'hB, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'd32);
      single("lui", 4'hE, 1'b0, 32'h0, 32'hABCD_1234, 32'h1234_0000);
      single("seq", 4'hF, 1'b0, 32'h55, 32'h55, 32'h1);

      // Back-to-back: new start presented during the done cycle.
      issue(4'h0, 1'b0, 32'h5, 32'h6);
      chk("b2b_first", {done, result}, {1'b1, 32'd11});
      issue(4'h4, 1'b0, 32'hF0, 32'hFF);
      chk("b2b_second", {done, result}, {1'b1, 32'h0F});

      issue(4'hC, 1'b1, 32'hFFFF_FFFE, 32'h3);
      op = 4'h0; a = 32'h0; b = 32'h0; sign = 1'b0;
      chk("mult_busy", busy, 1);
      wait_done(cyc, bcnt);
      chk("mult_latency", cyc, 32);
      chk("mult_busycnt", bcnt, 32);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("mult_res", result, 32'hFFFF_FFFA);

      issue(4'hC, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, bcnt);
      chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      issue(4'hD, 1'b1, 32'hFFFF_FFF9, 32'h2);
      wait_done(cyc, bcnt);
      chk("div_latency", cyc, 32);
      chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      issue(4'hD, 1'b0, 32'd100, 32'd7);
      wait_done(cyc, bcnt);
      chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

      issue(4'hD, 1'b1, 32'h1234_5678, 32'h0);
      chk("dz_done_busy", {done, busy}, 2'b10);
      chk("dz_flag", div_zero, 1);
      chk("dz_hilo", {hi, lo}, 64'h1234_5678_FFFF_FFFF);

      issue(4'hD, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc, bcnt);
      chk("divovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
      chk("divovf_flags", {overflow, div_zero}, 2'b10);

      // Reset in the middle of an iterative op.
      issue(4'hC, 1'b0, 32'h3, 32'h5);
      repeat (4) begin @(posedge clk); #1; end
      issue(4'h0, 1'b0, 32'h1, 32'h1);
      chk("ignored_start", {busy, done, result}, {2'b10, 32'h8000_0000});
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_hilo", {hi, lo}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      dn = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) dn++;
      end
      chk("midrst_nodone", dn, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (>=8, power of 2).
REQ-002 Parameter: CLZ_EN, 1, 1 enables CLZ/CLO; 0 makes those ops return 0.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  request; sampled only while busy=0.
REQ-006 Port: op  in  4  operation code (encoding in REQ-012).
REQ-007 Port: sign  in  1  1 = signed semantics for ADD/SUB/SLT/MULT/DIV.
REQ-008 Port: a, b  in  WIDTH  operands; b[log2(WIDTH)-1:0] is the shift amount.
REQ-009 Port: busy  out  1  high while an iterative op executes.
REQ-010 Port: done  out  1  one-cycle pulse; result/flags valid that cycle and held until next done.
REQ-011 Port: result, hi, lo  out  WIDTH each; zero, overflow, div_zero  out  1 each.

Function
REQ-012 Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, A CLZ, B CLO, C MULT, D DIV, E LUI (b[15:0] shifted left 16, zero-filled), F SEQ.
REQ-013 Single-cycle ops (0-B, E, F): start in cycle N -> done and registered outputs in cycle N+1; busy stays 0.
REQ-014 MULT: shift-add, one bit per cycle; busy from N+1 to N+WIDTH; done at N+WIDTH+1; {hi,lo} = full 2*WIDTH product; result = lo.
REQ-015 DIV: restoring, one bit per cycle, same timing as MULT; lo = quotient, hi = remainder; result = lo.
REQ-016 Signed MULT/DIV: operate on magnitudes, then negate; quotient sign = a^b, remainder sign = sign of a.
REQ-017 DIV with b=0: done at N+1, busy never asserted, div_zero=1, hi=a, lo=all ones.
REQ-018 Signed DIV of most-negative by -1: lo = most-negative, hi = 0, overflow=1.
REQ-019 overflow (ADD/SUB): sign=1 -> two's-complement overflow; sign=0 -> carry-out (ADD) or borrow (SUB); 0 for all other ops except REQ-018.
REQ-020 Shifts use only low log2(WIDTH) bits of b; shift amount 0 returns a unchanged.
REQ-021 SLT: sign=1 compares signed, else unsigned; result 1 or 0.
REQ-022 CLZ/CLO: a all-zero (CLZ) or all-one (CLO) returns WIDTH.
REQ-023 zero = (result == 0), registered with result.
REQ-024 hi/lo change only on MULT/DIV completion (incl. REQ-017); other ops leave them unchanged.
REQ-025 start while busy=1 is ignored; no queuing.
REQ-026 FSM states: IDLE, ITER, DONE. IDLE->ITER on start with MULT/DIV (b!=0 for DIV); IDLE->DONE on other start; ITER->DONE when bit counter reaches WIDTH-1; DONE->IDLE unconditionally; start sampled in DONE is accepted (back-to-back).
REQ-027 Operands and op latched at start; later changes to a/b/op/sign have no effect on the op in progress.

Reset
REQ-028 reset asserted: state=IDLE, busy=0, done=0, result/hi/lo=0, zero=1, overflow=0, div_zero=0, counter=0, immediately.
REQ-029 reset mid-iteration aborts the op; no done pulse is produced for it; hi/lo return to 0.

Structure
REQ-030 Package seq_alu_pkg holds op-code constants and FSM state type.
REQ-031 Sub-module seq_muldiv implements the iterative multiplier/divider datapath and bit counter; seq_alu holds the FSM, single-cycle ops and output registers.

Verification (WIDTH=32)
REQ-032 ADD a=7FFFFFFF b=1 sign=1 -> result 80000000, overflow=1, done at N+1, zero=0.
REQ-033 MULT a=FFFFFFFE b=3 sign=1 -> hi FFFFFFFF, lo FFFFFFFA, busy 32 cycles, done at N+33.
REQ-034 DIV a=-7 b=2 sign=1 -> lo FFFFFFFD, hi FFFFFFFF; then DIV b=0 -> div_zero=1, lo FFFFFFFF, done at N+1.
REQ-035 MULT start, second start at cycle N+5 with op ADD -> ignored; reset at N+10 -> busy=0, hi/lo=0, no done.
REQ-036 CLZ a=00010000 -> 15; CLZ a=0 -> 32; SRA a=80000000 b=4 -> F8000000.
